btb_next_pc: RTL and testbench

Fetch-side branch target buffer and next-PC redirect unit. It sits directly downstream of the local branch predictor. It pairs the predictor's registered direction bit with a registered BTB lookup of the same IF_PC, and issues a fetch redirect when both agree. It queues every prediction made, checks each one against the ID-stage resolution, and signals mispredict recovery with the correct PC.

---
 rtl/btb_next_pc.sv | 110 +++++++++++
 tb/tb_btb_next_pc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_next_pc.sv
// Fetch-side BTB with registered lookup and next-PC redirect. Every prediction is
// queued and checked against the in-order ID resolution; a mismatch raises a one-cycle recovery pulse.
module btb_next_pc #(
  parameter int IDX_BITS = 8,
  parameter int TAG_BITS = 22,
  parameter int Q_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  input  logic        IF_Valid,
  input  logic        Pred,
  input  logic        ID_Valid,
  input  logic [31:0] ID_PC,
  input  logic        Is_Branch,
  input  logic        Is_Taken,
  input  logic [31:0] Branch_Target,
  output logic        Redirect,
  output logic [31:0] Redirect_PC,
  output logic        Fetch_Hold,
  output logic        Mispredict,
  output logic [31:0] Recover_PC
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int QA      = $clog2(Q_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nxt;
  } qent_t;

  logic [ENTRIES-1:0]  btb_vld;
  logic [TAG_BITS-1:0] btb_tag [ENTRIES];
  logic [31:0]         btb_tgt [ENTRIES];

  logic        l_vld, l_hit;
  logic [31:0] l_pc, l_tgt;

  qent_t         q [Q_DEPTH];
  logic [QA-1:0] head, tail;
  logic [QA:0]   count;

  logic [IDX_BITS-1:0] if_idx, id_idx;
  logic [TAG_BITS-1:0] if_tag, id_tag;
  logic                lookup, push, pop, mis_next, btb_wr;
  logic [31:0]         resolved;

  assign if_idx = IF_PC[IDX_BITS+1:2];
  assign if_tag = IF_PC[31:IDX_BITS+2];
  assign id_idx = ID_PC[IDX_BITS+1:2];
  assign id_tag = ID_PC[31:IDX_BITS+2];

  assign Redirect    = l_vld & l_hit & Pred;
  assign Redirect_PC = Redirect ? l_tgt : '0;
  assign Fetch_Hold  = (int'(count) + int'(l_vld)) >= Q_DEPTH;

  assign lookup   = IF_Valid & ~Fetch_Hold & ~Mispredict;
  assign push     = l_vld;
  assign pop      = ID_Valid & (count != '0);
  assign resolved = (Is_Branch & Is_Taken) ? Branch_Target : ID_PC + 32'd4;
  assign mis_next = pop & (resolved != q[head].nxt);
  assign btb_wr   = ID_Valid & Is_Branch & Is_Taken;

  // Lookup reads the arrays before this edge's BTB write lands, so a same-index
  // read/write returns the old entry.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      btb_vld    <= '0;
      l_vld      <= 1'b0;
      l_hit      <= 1'b0;
      l_pc       <= '0;
      l_tgt      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      Mispredict <= 1'b0;
      Recover_PC <= '0;
    end else begin
      if (btb_wr) btb_vld[id_idx] <= 1'b1;
      l_vld <= lookup & ~mis_next;
      if (lookup) begin
        l_pc  <= IF_PC;
        l_hit <= btb_vld[if_idx] && (btb_tag[if_idx] == if_tag);
        l_tgt <= btb_tgt[if_idx];
      end
      Mispredict <= mis_next;
      Recover_PC <= mis_next ? resolved : '0;
      if (mis_next) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + {{QA{1'b0}}, push} - {{QA{1'b0}}, pop};
      end
    end
  end

  // Payload storage needs no reset: valid bits and the queue count qualify it.
  always_ff @(posedge CLK) begin
    if (btb_wr) begin
      btb_tag[id_idx] <= id_tag;
      btb_tgt[id_idx] <= Branch_Target;
    end
    if (push & ~mis_next)
      q[tail] <= '{pc: l_pc, nxt: Redirect ? l_tgt : l_pc + 32'd4};
  end

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed table plus randomized traffic for btb_next_pc, checked against a
// queue/array reference model and hand-computed expectations.
module tb_btb_next_pc;
  logic        CLK = 1'b0, RESET = 1'b0;
  logic [31:0] IF_PC = '0, ID_PC = '0, Branch_Target = '0;
  logic        IF_Valid = 1'b0, Pred = 1'b0, ID_Valid = 1'b0, Is_Branch = 1'b0, Is_Taken = 1'b0;
  logic        Redirect, Fetch_Hold, Mispredict;
  logic [31:0] Redirect_PC, Recover_PC;

  btb_next_pc dut (
    .CLK(CLK), .RESET(RESET), .IF_PC(IF_PC), .IF_Valid(IF_Valid), .Pred(Pred),
    .ID_Valid(ID_Valid), .ID_PC(ID_PC), .Is_Branch(Is_Branch), .Is_Taken(Is_Taken),
    .Branch_Target(Branch_Target), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .Fetch_Hold(Fetch_Hold), .Mispredict(Mispredict), .Recover_PC(Recover_PC)
  );

  always #5 CLK = ~CLK;

  int errs = 0, checks = 0;

  typedef struct {
    logic ifv; logic [31:0] ifpc; logic pred;
    logic idv; logic [31:0] idpc; logic br, tk; logic [31:0] tgt;
    logic red; logic [31:0] rpc; logic hold, mis; logic [31:0] rec;
  } vec_t;

  typedef struct { logic [31:0] pc, nxt; } qe_t;

  // Reference model: prediction queue, one lookup slot, BTB keyed by index holding the trained PC.
  qe_t         mq[$];
  bit          m_lv, m_lhit, m_mis;
  logic [31:0] m_lpc, m_ltgt, m_rec;
  bit          bv[256];
  logic [31:0] bpc[256], btgt[256];

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  function automatic vec_t mk(input logic ifv, input logic [31:0] ifpc, input logic pred,
                              input logic idv, input logic [31:0] idpc, input logic br, input logic tk,
                              input logic [31:0] tgt, input logic red, input logic [31:0] rpc,
                              input logic hold, input logic mis, input logic [31:0] rec);
    vec_t v;
    v.ifv = ifv; v.ifpc = ifpc; v.pred = pred; v.idv = idv; v.idpc = idpc; v.br = br; v.tk = tk;
    v.tgt = tgt; v.red = red; v.rpc = rpc; v.hold = hold; v.mis = mis; v.rec = rec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lv = 0; m_lhit = 0; m_mis = 0; m_lpc = 0; m_ltgt = 0; m_rec = 0;
    foreach (bv[i]) bv[i] = 0;
  endtask

  task automatic model_step();
    bit hold, red, mis_n, pop;
    logic [31:0] res;
    int li, wi;
    hold  = (mq.size() + int'(m_lv)) >= 4;
    red   = m_lv && m_lhit && Pred;
    mis_n = 0; pop = 0; res = 0;
    if (ID_Valid && mq.size() > 0) begin
      pop   = 1;
      res   = (Is_Branch && Is_Taken) ? Branch_Target : ID_PC + 32'd4;
      mis_n = (res != mq[0].nxt);
    end
    if (mis_n) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (m_lv) mq.push_back('{pc: m_lpc, nxt: red ? m_ltgt : m_lpc + 32'd4});
    end
    if (IF_Valid && !hold && !m_mis && !mis_n) begin
      li     = idx(IF_PC);
      m_lv   = 1;
      m_lpc  = IF_PC;
      m_lhit = bv[li] && ((bpc[li] >> 10) == (IF_PC >> 10));
      m_ltgt = btgt[li];
    end else m_lv = 0;
    if (ID_Valid && Is_Branch && Is_Taken) begin
      wi = idx(ID_PC); bv[wi] = 1; bpc[wi] = ID_PC; btgt[wi] = Branch_Target;
    end
    m_mis = mis_n;
    m_rec = mis_n ? res : 32'd0;
  endtask

  task automatic apply(input vec_t v);
    IF_Valid = v.ifv; IF_PC = v.ifpc; Pred = v.pred;
    ID_Valid = v.idv; ID_PC = v.idpc; Is_Branch = v.br; Is_Taken = v.tk; Branch_Target = v.tgt;
  endtask

  // One cycle: outputs sampled at negedge against model (and table if use_e), model advances at posedge.
  task automatic cyc(input bit use_e, input vec_t v, input string tag);
    bit mred;
    apply(v);
    @(negedge CLK);
    mred = m_lv && m_lhit && Pred;
    chk({tag, " model redirect"}, Redirect, mred);
    chk({tag, " model redirect_pc"}, Redirect_PC, mred ? m_ltgt : 32'd0);
    chk({tag, " model hold"}, Fetch_Hold, (mq.size() + int'(m_lv)) >= 4);
    chk({tag, " model mispredict"}, Mispredict, m_mis);
    chk({tag, " model recover_pc"}, Recover_PC, m_rec);
    if (use_e) begin
      chk({tag, " redirect"}, Redirect, v.red);
      chk({tag, " redirect_pc"}, Redirect_PC, v.rpc);
      chk({tag, " hold"}, Fetch_Hold, v.hold);
      chk({tag, " mispredict"}, Mispredict, v.mis);
      chk({tag, " recover_pc"}, Recover_PC, v.rec);
    end
    @(posedge CLK);
    model_step();
    #1;
  endtask

  vec_t        tbl[$];
  vec_t        rv;
  logic [31:0] pcs[8];
  logic [31:0] tgs[4];

  initial begin
    pcs = '{32'h100, 32'h500, 32'h104, 32'h900, 32'h2000, 32'h2400, 32'h3000, 32'h504};
    tgs = '{32'h200, 32'h800, 32'h104, 32'h4000};

    // ifv ifpc pred | idv idpc br tk tgt | red rpc hold mis rec
    tbl.push_back(mk(1, 'h100, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));    // miss
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h100, 1, 0, 0,       0, 0, 0, 0, 0));    // not-taken matches 0x104
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h100, 1, 1, 'h200,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100, 1, 0, 0, 0, 0, 0,       0, 0, 0, 1, 'h200)); // pulse, fetch ignored
    tbl.push_back(mk(1, 'h100, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,           1, 'h200, 0, 0, 0)); // trained hit
    tbl.push_back(mk(0, 0, 0, 1, 'h100, 1, 1, 'h200,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));    // hit but Pred=0
    tbl.push_back(mk(0, 0, 0, 1, 'h100, 1, 1, 'h200,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 'h200));
    tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h1004, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h1008, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100c, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h1010, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));    // count 3 + L 1
    tbl.push_back(mk(1, 'h1010, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 'h1010, 0, 1, 'h1000, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));    // hold released
    tbl.push_back(mk(0, 0, 0, 1, 'h1004, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h1008, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h100c, 0, 0, 0,      0, 0, 0, 0, 0));
    // 0x500 shares index 0x40 with 0x100; same-edge lookup sees the old 0x100 entry
    tbl.push_back(mk(1, 'h500, 1, 1, 'h500, 1, 1, 'h800, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0));    // 0x100 evicted
    tbl.push_back(mk(0, 0, 0, 1, 'h500, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h100, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h500, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,           1, 'h800, 0, 0, 0));
    tbl.push_back(mk(1, 'h500, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h500, 1, 0, 0, 0, 0, 0,       1, 'h800, 0, 0, 0));
    tbl.push_back(mk(1, 'h500, 1, 0, 0, 0, 0, 0,       1, 'h800, 0, 0, 0));

    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset redirect", Redirect, 0);
    chk("reset redirect_pc", Redirect_PC, 0);
    chk("reset hold", Fetch_Hold, 0);
    chk("reset mispredict", Mispredict, 0);
    chk("reset recover_pc", Recover_PC, 0);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK);
    #1;

    foreach (tbl[i]) cyc(1, tbl[i], $sformatf("row%0d", i));

    // Mid-flight reset: queue holds 3, lookup slot holds a hit with Pred=1
    IF_Valid = 0; ID_Valid = 0; Pred = 1;
    #1;
    chk("pre-reset redirect", Redirect, 1);
    RESET = 1'b0;
    #1;
    chk("async reset redirect", Redirect, 0);
    chk("async reset redirect_pc", Redirect_PC, 0);
    chk("async reset hold", Fetch_Hold, 0);
    chk("async reset mispredict", Mispredict, 0);
    chk("async reset recover_pc", Recover_PC, 0);
    model_reset();
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK);
    #1;
    cyc(1, mk(1, 'h500, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post-reset fetch");
    cyc(1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post-reset miss");

    for (int n = 0; n < 1500; n++) begin
      rv = mk($urandom_range(9) < 7, pcs[$urandom_range(7)], 1'($urandom_range(1)),
              $urandom_range(9) < 4, pcs[$urandom_range(7)], 1'($urandom_range(1)),
              1'($urandom_range(1)), tgs[$urandom_range(3)], 0, 0, 0, 0, 0);
      cyc(0, rv, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
